// File: rtl/bist_engine.sv
// Built-in self-test engine: drives a vector sequence onto a DUT port and either
// compares responses against a stored table or compacts them into a MISR signature.
module bist_engine #(
    parameter int          W     = 4,
    parameter int          DEPTH = 17,
    parameter int          LAT   = 1,
    parameter logic [W-1:0] POLY = W'(4'b0011),
    localparam int         IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int         DW    = $clog2(DEPTH + LAT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          mode_i,
    input  logic          vec_we_i,
    input  logic [IW-1:0] vec_addr_i,
    input  logic [W-1:0]  stim_wdata_i,
    input  logic [W-1:0]  exp_wdata_i,
    input  logic [W-1:0]  seed_i,
    input  logic [W-1:0]  sig_ref_i,
    input  logic [W-1:0]  state_i,
    output logic [W-1:0]  drive_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          pass_o,
    output logic [IW-1:0] fail_idx_o,
    output logic [IW:0]   fail_cnt_o,
    output logic [DW-1:0] duration_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int SW = 1 + IW + W;

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [W-1:0]  lfsr_q, lfsr_d;
    logic [W-1:0]  misr_q, misr_d;
    logic [DW-1:0] dur_q, dur_d;
    logic [IW:0]   fail_cnt_q, fail_cnt_d;
    logic [IW-1:0] fail_idx_q, fail_idx_d;
    logic          res_vld_q, res_vld_d;
    logic          sig_ok_q, sig_ok_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          start_ok, in_busy, do_abort, dl_clr, mem_we;
    logic [IW-1:0] rd_addr;
    logic [W-1:0]  stim_rd_q, exp_rd_q;
    logic [SW-1:0] stage0, stage_cmp;
    logic          cmp_vld;
    logic [IW-1:0] cmp_idx;
    logic [W-1:0]  cmp_exp;

    logic [W-1:0]  stim_mem [DEPTH];
    logic [W-1:0]  exp_mem  [DEPTH];

    function automatic logic [W-1:0] galois_step(input logic [W-1:0] v);
        return {v[W-2:0], 1'b0} ^ (v[W-1] ? POLY : '0);
    endfunction

    assign start_ok = (state_q == S_IDLE) && start_i && !abort_i;
    assign in_busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign do_abort = in_busy && abort_i;
    assign dl_clr   = start_ok || do_abort;
    assign mem_we   = vec_we_i && (state_q == S_IDLE) && (int'(vec_addr_i) < DEPTH);

    // Vector tables are read one cycle ahead so the word for vector k is ready in RUN cycle k.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            stim_mem[vec_addr_i] <= stim_wdata_i;
            exp_mem[vec_addr_i]  <= exp_wdata_i;
        end
        stim_rd_q <= stim_mem[rd_addr];
        exp_rd_q  <= exp_mem[rd_addr];
    end

    // Each stage carries {valid, index, expected} so the compare lines up with the DUT latency.
    assign stage0 = {state_q == S_RUN, dur_q[IW-1:0], exp_rd_q};

    generate
        if (LAT > 0) begin : g_dl
            logic [SW-1:0] dl_q [LAT];
            logic [SW-1:0] dl_d [LAT];
            for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    assign dl_d[gi] = dl_clr ? '0 : stage0;
                end else begin : g_tail
                    assign dl_d[gi] = dl_clr ? '0 : dl_q[gi-1];
                end
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < LAT; j++) dl_q[j] <= '0;
                end else begin
                    for (int j = 0; j < LAT; j++) dl_q[j] <= dl_d[j];
                end
            end
            assign stage_cmp = dl_q[LAT-1];
        end else begin : g_nodl
            assign stage_cmp = stage0;
        end
    endgenerate

    assign {cmp_vld, cmp_idx, cmp_exp} = stage_cmp;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        lfsr_d     = lfsr_q;
        misr_d     = misr_q;
        dur_d      = dur_q;
        fail_cnt_d = fail_cnt_q;
        fail_idx_d = fail_idx_q;
        res_vld_d  = res_vld_q;
        sig_ok_d   = sig_ok_q;
        rd_addr    = '0;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d    = S_RUN;
                    mode_d     = mode_i;
                    lfsr_d     = (seed_i == '0) ? W'(1) : seed_i;
                    misr_d     = '0;
                    dur_d      = '0;
                    fail_cnt_d = '0;
                    fail_idx_d = '1;
                    res_vld_d  = 1'b0;
                    sig_ok_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (dur_q != DW'(DEPTH - 1)) rd_addr = dur_q[IW-1:0] + IW'(1);
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    lfsr_d = galois_step(lfsr_q);
                    if (dur_q == DW'(DEPTH - 1)) begin
                        state_d   = (LAT == 0) ? S_DONE : S_DRAIN;
                        res_vld_d = (LAT == 0);
                    end
                end
            end
            S_DRAIN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (dur_q == DW'(DEPTH + LAT - 1)) begin
                    state_d   = S_DONE;
                    res_vld_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                sig_ok_d = (misr_q == sig_ref_i);
            end
            default: state_d = S_IDLE;
        endcase

        if (in_busy) dur_d = dur_q + DW'(1);

        // The edge that takes an abort does not fold in a response.
        if (in_busy && !abort_i && cmp_vld) begin
            if (mode_q) begin
                misr_d = galois_step(misr_q) ^ state_i;
            end else if (state_i != cmp_exp) begin
                if (fail_cnt_q == '0) fail_idx_d = cmp_idx;
                if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + (IW+1)'(1);
            end
        end

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            lfsr_q     <= '0;
            misr_q     <= '0;
            dur_q      <= '0;
            fail_cnt_q <= '0;
            fail_idx_q <= '1;
            res_vld_q  <= 1'b0;
            sig_ok_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            lfsr_q     <= lfsr_d;
            misr_q     <= misr_d;
            dur_q      <= dur_d;
            fail_cnt_q <= fail_cnt_d;
            fail_idx_q <= fail_idx_d;
            res_vld_q  <= res_vld_d;
            sig_ok_q   <= sig_ok_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // The signature reference is only looked at in DONE, so the verdict for that cycle is live.
    assign pass_o     = res_vld_q && (mode_q ? (done_q ? (misr_q == sig_ref_i) : sig_ok_q)
                                             : (fail_cnt_q == '0));
    assign drive_o    = (state_q == S_RUN) ? (mode_q ? lfsr_q : stim_rd_q) : '0;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign fail_idx_o = fail_idx_q;
    assign fail_cnt_o = fail_cnt_q;
    assign duration_o = dur_q;

endmodule

// File: tb/tb_bist_engine.sv
// Scoreboard bench for bist_engine: a behavioural model queues expected drive words and
// run results; a negedge monitor pops and compares them as the engine produces them.
module tb_bist_engine;
    localparam int             W     = 4;
    localparam int             DEPTH = 5;
    localparam int             LAT   = 1;
    localparam logic [W-1:0]   POLY  = 4'b0011;
    localparam int             IW    = $clog2(DEPTH);
    localparam int             DW    = $clog2(DEPTH + LAT + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i, abort_i, mode_i, vec_we_i;
    logic [IW-1:0] vec_addr_i;
    logic [W-1:0]  stim_wdata_i, exp_wdata_i, seed_i, sig_ref_i;
    logic [W-1:0]  state_i = '0;
    logic [W-1:0]  drive_o;
    logic          busy_o, done_o, pass_o;
    logic [IW-1:0] fail_idx_o;
    logic [IW:0]   fail_cnt_o;
    logic [DW-1:0] duration_o;

    int errors = 0;
    int checks = 0;
    int run_no = 0;

    typedef struct {
        logic          pass;
        logic [IW-1:0] idx;
        logic [IW:0]   cnt;
        logic [DW-1:0] dur;
    } res_t;

    res_t         res_q[$];
    logic [W-1:0] drv_q[$];
    logic [W-1:0] stim_m [DEPTH];
    logic [W-1:0] exp_m  [DEPTH];

    bist_engine #(.W(W), .DEPTH(DEPTH), .LAT(LAT), .POLY(POLY)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .mode_i(mode_i),
        .vec_we_i(vec_we_i), .vec_addr_i(vec_addr_i), .stim_wdata_i(stim_wdata_i),
        .exp_wdata_i(exp_wdata_i), .seed_i(seed_i), .sig_ref_i(sig_ref_i), .state_i(state_i),
        .drive_o(drive_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .fail_idx_o(fail_idx_o), .fail_cnt_o(fail_cnt_o), .duration_o(duration_o)
    );

    always #5 clk = ~clk;

    // DUT under test modelled as a one-cycle register loopback.
    always @(posedge clk) state_i <= drive_o;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] step(input logic [W-1:0] v);
        return {v[W-2:0], 1'b0} ^ (v[W-1] ? POLY : '0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: drive_o against the queued sequence, results on every done pulse.
    int busy_cyc = 0;
    always @(negedge clk) begin
        if (busy_o && busy_cyc < DEPTH) begin
            if (drv_q.size() > 0) chk("drive", int'(drive_o), int'(drv_q.pop_front()));
        end else begin
            chk("drive_zero", int'(drive_o), 0);
        end
        busy_cyc = busy_o ? busy_cyc + 1 : 0;
        if (done_o) begin
            if (res_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done_o=1, expected 0 (t=%0t)", $time);
            end else begin : pop_res
                res_t r;
                r = res_q.pop_front();
                chk("pass", int'(pass_o), int'(r.pass));
                chk("fail_idx", int'(fail_idx_o), int'(r.idx));
                chk("fail_cnt", int'(fail_cnt_o), int'(r.cnt));
                chk("duration", int'(duration_o), int'(r.dur));
            end
        end
    end

    // Reference model: derives the drive sequence and result of a run from the tables/seed.
    task automatic expect_run(input logic mode, input logic [W-1:0] seed, input logic flip,
                              output logic exp_pass);
        logic [W-1:0] l, m, d;
        res_t r;
        int cnt;
        l = (seed == '0) ? W'(1) : seed;
        m = '0;
        cnt = 0;
        r.idx = '1;
        for (int k = 0; k < DEPTH; k++) begin
            d = mode ? l : stim_m[k];
            drv_q.push_back(d);
            l = step(l);
            m = step(m) ^ d;
            if (!mode && d != exp_m[k]) begin
                if (cnt == 0) r.idx = IW'(k);
                cnt++;
            end
        end
        r.cnt  = (IW+1)'(cnt);
        r.pass = mode ? !flip : (cnt == 0);
        r.dur  = DW'(DEPTH + LAT);
        res_q.push_back(r);
        mode_i    = mode;
        seed_i    = seed;
        sig_ref_i = flip ? (m ^ W'(1)) : m;
        exp_pass  = r.pass;
    endtask

    task automatic load_tables();
        for (int k = 0; k < DEPTH; k++) begin
            vec_we_i = 1'b1;
            vec_addr_i = IW'(k);
            stim_wdata_i = stim_m[k];
            exp_wdata_i = exp_m[k];
            tick();
        end
        if (DEPTH < (1 << IW)) begin
            vec_addr_i = IW'(DEPTH);
            stim_wdata_i = W'($urandom);
            exp_wdata_i = W'($urandom);
            tick();
        end
        vec_we_i = 1'b0;
    endtask

    task automatic start_pulse();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("busy_high", int'(busy_o), 1);
    endtask

    task automatic wait_done(input logic exp_pass);
        int n;
        n = 0;
        while (res_q.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        run_no++;
        if (res_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done_o after %0d cycles, expected one", n);
            res_q.delete();
            drv_q.delete();
        end else begin
            chk("pass_hold", int'(pass_o), int'(exp_pass));
            chk("dur_hold", int'(duration_o), DEPTH + LAT);
            chk("done_low", int'(done_o), 0);
            $display("run %0d: mode=%0d pass=%0d fail_cnt=%0d fail_idx=%0d duration=%0d",
                     run_no, mode_i, pass_o, fail_cnt_o, fail_idx_o, duration_o);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_drive"}, int'(drive_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
        chk({tag, "_pass"}, int'(pass_o), 0);
        chk({tag, "_fail_idx"}, int'(fail_idx_o), (1 << IW) - 1);
        chk({tag, "_fail_cnt"}, int'(fail_cnt_o), 0);
        chk({tag, "_duration"}, int'(duration_o), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected one before 1ms");
        $fatal(1);
    end

    initial begin
        logic p, seen;
        rst_n = 1'b0;
        start_i = 1'b0; abort_i = 1'b0; mode_i = 1'b0; vec_we_i = 1'b0;
        vec_addr_i = '0; stim_wdata_i = '0; exp_wdata_i = '0; seed_i = '0; sig_ref_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Table mode, all vectors match.
        for (int k = 0; k < DEPTH; k++) begin
            stim_m[k] = W'(k + 1);
            exp_m[k]  = W'(k + 1);
        end
        load_tables();
        expect_run(1'b0, '0, 1'b0, p);
        start_pulse();
        wait_done(p);

        // Table mode with two mismatching expectations.
        exp_m[1] = W'(9);
        exp_m[3] = W'(0);
        load_tables();
        expect_run(1'b0, '0, 1'b0, p);
        start_pulse();
        wait_done(p);

        // LFSR mode, zero seed, correct then corrupted signature (back to back).
        expect_run(1'b1, '0, 1'b0, p);
        start_pulse();
        wait_done(p);
        expect_run(1'b1, '0, 1'b1, p);
        start_pulse();
        wait_done(p);

        // Abort during the second RUN cycle.
        expect_run(1'b0, '0, 1'b0, p);
        res_q.delete();
        start_pulse();
        tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        drv_q.delete();
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_done", int'(done_o), 0);
        chk("abort_pass", int'(pass_o), 0);
        chk("abort_drive", int'(drive_o), 0);
        seen = 1'b0;
        repeat (4) begin
            tick();
            seen |= done_o;
        end
        chk("abort_no_done", int'(seen), 0);
        chk("abort_pass_hold", int'(pass_o), 0);

        // start_i and vec_we_i while running are ignored; a repeat run sees the same tables.
        expect_run(1'b0, '0, 1'b0, p);
        start_pulse();
        tick();
        start_i = 1'b1;
        vec_we_i = 1'b1;
        vec_addr_i = '0;
        stim_wdata_i = ~stim_m[0];
        exp_wdata_i = ~exp_m[0];
        tick();
        start_i = 1'b0;
        vec_we_i = 1'b0;
        wait_done(p);
        expect_run(1'b0, '0, 1'b0, p);
        start_pulse();
        wait_done(p);

        // Simultaneous start and abort in IDLE start nothing.
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("start_abort_busy", int'(busy_o), 0);
        tick();
        chk("start_abort_busy2", int'(busy_o), 0);

        // Asynchronous reset mid-run, then a fresh run.
        expect_run(1'b1, W'($urandom), 1'b0, p);
        start_pulse();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        res_q.delete();
        drv_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        expect_run(1'b0, '0, 1'b0, p);
        start_pulse();
        wait_done(p);

        // Randomized runs.
        for (int it = 0; it < 10; it++) begin
            for (int k = 0; k < DEPTH; k++) begin
                stim_m[k] = W'($urandom);
                exp_m[k]  = ($urandom_range(2) == 0) ? W'($urandom) : stim_m[k];
            end
            load_tables();
            expect_run(1'($urandom_range(1)), W'($urandom), 1'($urandom_range(1)), p);
            start_pulse();
            wait_done(p);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bist_engine.md
# bist_engine

Parametrised built-in self-test engine for the JTAG test datapath. It drives a stimulus sequence onto a DUT port and checks the responses in one of two modes. In table mode it compares against stored expected values and reports the first failing index and a mismatch count. In LFSR mode it generates pseudo-random stimulus and compacts responses into a MISR signature. It sits between the TAP user-data registers (control, vector load, results) and the DUT-under-test port.

## Interface
- W, default 4: stimulus/response width (>=2)
- DEPTH, default 17: vectors per run (>=1)
- LAT, default 1: DUT response latency in cycles (>=0)
- POLY, default 4'b0011: Galois feedback taps for LFSR and MISR, width W
- IW = $clog2(DEPTH) (min 1); DW = $clog2(DEPTH+LAT+1) (min 1); derived, not overridable
- clk  in  1  clock; reset rst_n, asynchronous, active-low; clock clk
- rst_n  in  1  async active-low reset
- start_i  in  1  start request, sampled only in IDLE
- abort_i  in  1  abort request; wins over start_i
- mode_i  in  1  0 = table compare, 1 = LFSR/MISR; latched at start
- vec_we_i  in  1  vector memory write strobe
- vec_addr_i  in  IW  vector memory index
- stim_wdata_i  in  W  stimulus word
- exp_wdata_i  in  W  expected word
- seed_i  in  W  LFSR seed; latched at start
- sig_ref_i  in  W  expected MISR signature; sampled in the DONE cycle
- state_i  in  W  DUT response
- drive_o  out  W  stimulus to DUT
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle completion pulse
- pass_o  out  1  run result, valid from done until next start
- fail_idx_o  out  IW  first failing vector index
- fail_cnt_o  out  IW+1  mismatch count, saturating
- duration_o  out  DW  busy cycles elapsed

## Operation
- FSM states and transitions:
  - IDLE -> RUN on start_i & ~abort_i.
  - RUN lasts DEPTH cycles, then goes to DRAIN; if LAT=0, RUN goes directly to DONE.
  - DRAIN lasts LAT cycles, then goes to DONE.
  - DONE lasts 1 cycle, then returns to IDLE.
- Vector memories: two DEPTH x W arrays (stim, exp).
  - A write occurs on vec_we_i in IDLE only.
  - Writes while busy are ignored; writes with vec_addr_i >= DEPTH are ignored.
  - Contents are not reset.
- Stimulus:
  - Mode 0: drive_o = stim[k] during the k-th RUN cycle.
  - Mode 1: drive_o = LFSR. The LFSR loads seed_i at start, with a seed of 0 replaced by 1. Each RUN cycle it steps as lfsr <= {lfsr[W-2:0],0} ^ (lfsr[W-1] ? POLY : 0).
  - drive_o = 0 outside RUN.
- Compare:
  - The response to vector k is sampled at the clock edge that ends the cycle LAT cycles after vector k was driven.
  - Implement this with a LAT-deep delay line carrying the valid bit, the index, and the expected value.
- Mode 0 result:
  - Each mismatch increments fail_cnt (saturates at 2^(IW+1)-1).
  - The first mismatch records fail_idx.
  - pass_o = (fail_cnt == 0).
- Mode 1 result:
  - The MISR starts at 0.
  - Per sampled response: misr <= ({misr[W-2:0],0} ^ (misr[W-1] ? POLY : 0)) ^ state_i.
  - pass_o = (misr == sig_ref_i), evaluated in DONE.
  - fail_cnt_o stays 0; fail_idx_o stays all-ones.
- Results are cleared at start: pass_o = 0, fail_cnt_o = 0, fail_idx_o = all-ones, duration_o = 0.
- Abort:
  - In RUN or DRAIN, the FSM goes to IDLE on the next edge.
  - done_o is not pulsed, pass_o = 0, and the other results hold their partial values.
  - abort_i in IDLE or DONE has no effect.
- start_i while busy or in DONE is ignored.
- Asynchronous reset mid-run returns the block to IDLE with all outputs at their reset values.

## Timing
- Reset values: drive_o = 0, busy_o = 0, done_o = 0, pass_o = 0, fail_idx_o = all-ones, fail_cnt_o = 0, duration_o = 0.
- Let t0 be the cycle in which start_i is sampled high in IDLE.
- Vector k is on drive_o during cycle t0+1+k.
- The response to vector k is sampled at the end of cycle t0+1+k+LAT.
- busy_o is high during cycles t0+1 through t0+DEPTH+LAT.
- done_o is high during cycle t0+DEPTH+LAT+1; pass_o is valid in that same cycle.
- duration_o increments at each busy cycle edge, equals DEPTH+LAT at done, and holds until the next start.
- A new start may be sampled in the cycle after done_o.

## Test plan
- Mode 0 pass. Setup: DEPTH=4, LAT=1, stim = exp = {1,2,3,4}, DUT modelled as a 1-cycle register loopback. Start at t0 -> drive_o = 1,2,3,4 in cycles t0+1..t0+4; done_o at t0+6; pass_o = 1; duration_o = 5; fail_cnt_o = 0; fail_idx_o = 3.
- Mode 0 mismatches. Same setup, with exp[1] = 9 and exp[3] = 0 -> pass_o = 0; fail_idx_o = 1; fail_cnt_o = 2.
- Mode 1 with W=4, DEPTH=5, seed_i = 0 -> drive_o = 1, 2, 4, 8, 3. With sig_ref_i set to the model MISR -> pass_o = 1; with sig_ref_i flipped in bit 0 -> pass_o = 0.
- Abort at t0+2 -> busy_o low from t0+3; no done_o pulse; pass_o = 0; drive_o = 0.
- start_i asserted during RUN, and vec_we_i asserted during RUN -> both ignored; the run result is unchanged. Simultaneous start_i and abort_i in IDLE -> no run starts.
- rst_n asserted at t0+3 -> all outputs at reset values immediately. A fresh start then completes with correct results.
